ro_sum_accumulator: RTL
=======================

Name: ro_sum_accumulator

Overview:
Measurement stage directly upstream of the measurement/UART control FSM. It samples the asynchronous ring-oscillator output and counts its rising edges over NUM_WINDOWS fixed gate windows of GATE_CYCLES clocks each. It returns the accumulated count as sum, with a one-cycle sum_ready pulse, under the FSM's sum_en handshake. It also provides the byte-select mux that feeds the UART transmitter according to send_sel.

Parameters:
GATE_CYCLES, 1000, clocks per gate window (>=2)
NUM_WINDOWS, 4, windows accumulated per measurement (>=1)
SUM_W, 16, width of sum/accumulator (8..16)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
ro_in  input  1  ring-oscillator output, asynchronous to clk
sum_en  input  1  measurement request from control FSM (level)
send_sel  input  2  byte select from control FSM
sum  output  SUM_W  last completed measurement, registered
sum_ready  output  1  one-cycle pulse: sum just updated
overflow  output  1  last measurement saturated, registered
tx_data  output  8  byte presented to UART transmitter

Behaviour:
- Reset (async, active-high): state=IDLE; sum=0, sum_ready=0, overflow=0; sync flops, counters and accumulator cleared.
- Input path: 2-flop synchronizer on ro_in, then a third flop for edge detect; edge = sync & ~prev. Edge-to-count latency is 3 clocks.
- Edge counter: localparam width = $clog2(GATE_CYCLES+1); saturates at all-ones (unreachable for sane params).
- States: IDLE, GATE, ACCUM, DONE.
- IDLE: if sum_en=1 -> GATE; clear gate timer, window index, edge counter, accumulator, overflow-pending.
- GATE: count edges each cycle; gate timer runs 0..GATE_CYCLES-1; an edge in the final GATE cycle is counted. After the final cycle -> ACCUM.
- ACCUM (1 cycle, edges ignored):
  - acc = acc + edge_cnt, saturating at 2^SUM_W-1; saturation sets overflow-pending.
  - Clear the edge counter.
  - If window index = NUM_WINDOWS-1 -> DONE; on this transition sum<=acc (saturated value) and overflow<=pending.
  - Else increment window index -> GATE.
- DONE (1 cycle): sum_ready=1 (registered, high only in DONE), then -> IDLE.
- Latency: sum_en sampled high in IDLE at cycle 0 -> sum_ready high in cycle NUM_WINDOWS*(GATE_CYCLES+1)+1, with sum valid that cycle.
- sum_en low in GATE or ACCUM: abort to IDLE next cycle; sum and overflow unchanged; no sum_ready.
- sum_en still high after DONE: IDLE restarts a new measurement on the next cycle. The FSM normally drops sum_en after sum_ready.
- sum and overflow hold their value until the next completed measurement.
- tx_data (combinational from registers):
  - send_sel=0 -> sum[7:0]
  - send_sel=1 -> sum[SUM_W-1:8], zero-extended; 8'h00 if SUM_W=8
  - send_sel=2 -> {7'b0, overflow}
  - send_sel=3 -> 8'h00
- Reset mid-measurement: immediate return to reset values; partial data discarded.

Decomposition:
- Shared package ro_sense_pkg: state encoding localparams (IDLE=0, GATE=1, ACCUM=2, DONE=3) and send_sel codes (SEL_LO=0, SEL_HI=1, SEL_STAT=2). The control FSM uses the same send_sel codes.
- One sub-module, ro_edge_sync: 2-flop synchronizer plus edge-detect flop. Ports: clk, reset, async_in, edge_pulse.

Test Plan:
1. G=10, N=4, ro_in toggling every clk (edge every 2 clks), sum_en held high -> sum_ready in cycle 45; sum=20, overflow=0; sum_ready exactly 1 cycle wide.
2. G=10, N=4, ro_in constant 0, then constant 1 -> sum=0 both times, sum_ready still pulses at cycle 45.
3. SUM_W=8, G=200, N=4, edge every 2 clks (400 total) -> sum=255, overflow=1; send_sel=2 gives tx_data=8'h01; send_sel=1 gives 8'h00.
4. After scenario 1, sum_en dropped at cycle 20 of a new run -> state IDLE next cycle, no sum_ready, sum stays 20.
5. reset asserted asynchronously mid-GATE -> sum=0, sum_ready=0, overflow=0 immediately; a new run after release gives sum=20 (scenario-1 stimulus).
6. G=1000, N=4, period-6 ro_in (edge every 6 clks) -> sum within 666±4; tx_data = sum[7:0] for send_sel=0 and sum[15:8] for send_sel=1.

Source files
------------

// File: rtl/ro_sense_pkg.sv
// Shared encodings for the ring-oscillator measurement path: FSM states
// and the byte-select codes the control FSM drives on send_sel.
package ro_sense_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] SEL_LO   = 2'd0;
  localparam logic [1:0] SEL_HI   = 2'd1;
  localparam logic [1:0] SEL_STAT = 2'd2;

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchronizer for the asynchronous ring-oscillator output, plus
// a history flop so a rising edge becomes a single-cycle pulse.
module ro_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic edge_pulse
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign edge_pulse = sync_q & ~prev_q;

endmodule

// File: rtl/ro_sum_accumulator.sv
// Counts ring-oscillator edges over NUM_WINDOWS gate windows, publishes a
// saturating sum with a one-cycle ready pulse, and muxes bytes for the UART.
module ro_sum_accumulator
  import ro_sense_pkg::*;
#(
  parameter int GATE_CYCLES = 1000,
  parameter int NUM_WINDOWS = 4,
  parameter int SUM_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ro_in,
  input  logic             sum_en,
  input  logic [1:0]       send_sel,
  output logic [SUM_W-1:0] sum,
  output logic             sum_ready,
  output logic             overflow,
  output logic [7:0]       tx_data
);

  localparam int CNT_W = $clog2(GATE_CYCLES + 1);
  localparam int TMR_W = $clog2(GATE_CYCLES);
  localparam int WIN_W = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1;
  localparam int EXT_W = ((SUM_W > CNT_W) ? SUM_W : CNT_W) + 1;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(NUM_WINDOWS - 1);
  localparam logic [EXT_W-1:0] SUM_MAX  = {{(EXT_W-SUM_W){1'b0}}, {SUM_W{1'b1}}};

  state_e           state_q;
  logic [TMR_W-1:0] tmr_q;
  logic [WIN_W-1:0] win_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SUM_W-1:0] acc_q;
  logic             ovf_pend_q;
  logic [SUM_W-1:0] sum_q;
  logic             ovf_q;
  logic             rdy_q;

  logic             edge_w;
  logic [CNT_W-1:0] cnt_d;
  logic [EXT_W-1:0] acc_ext_d;
  logic             acc_sat_d;
  logic [SUM_W-1:0] acc_d;
  logic [7:0]       hi_byte;

  ro_edge_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .async_in   (ro_in),
    .edge_pulse (edge_w)
  );

  // Both the edge counter and the accumulator clamp rather than wrap.
  assign cnt_d     = (edge_w && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;
  assign acc_ext_d = EXT_W'(acc_q) + EXT_W'(cnt_q);
  assign acc_sat_d = (acc_ext_d > SUM_MAX);
  assign acc_d     = acc_sat_d ? {SUM_W{1'b1}} : acc_ext_d[SUM_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      win_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      ovf_pend_q <= 1'b0;
      sum_q      <= '0;
      ovf_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tmr_q      <= '0;
          win_q      <= '0;
          cnt_q      <= '0;
          acc_q      <= '0;
          ovf_pend_q <= 1'b0;
          if (sum_en) state_q <= GATE;
        end
        GATE: begin
          if (!sum_en) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
            if (tmr_q == TMR_LAST) begin
              tmr_q   <= '0;
              state_q <= ACCUM;
            end else begin
              tmr_q <= tmr_q + 1'b1;
            end
          end
        end
        ACCUM: begin
          if (!sum_en) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= '0;
            if (acc_sat_d) ovf_pend_q <= 1'b1;
            if (win_q == WIN_LAST) begin
              sum_q   <= acc_d;
              ovf_q   <= ovf_pend_q | acc_sat_d;
              rdy_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              win_q   <= win_q + 1'b1;
              state_q <= GATE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  generate
    if (SUM_W > 8) begin : g_hi
      assign hi_byte = 8'(sum_q[SUM_W-1:8]);
    end else begin : g_no_hi
      assign hi_byte = 8'h00;
    end
  endgenerate

  always_comb begin
    tx_data = 8'h00;
    case (send_sel)
      SEL_LO:   tx_data = sum_q[7:0];
      SEL_HI:   tx_data = hi_byte;
      SEL_STAT: tx_data = {7'b0, ovf_q};
      default:  tx_data = 8'h00;
    endcase
  end

  assign sum       = sum_q;
  assign sum_ready = rdy_q;
  assign overflow  = ovf_q;

endmodule
